// File: rtl/rf_op_sequencer.sv
// Executes one register-file command at a time. An ALU op writes three cycles after accept and MOVI writes one cycle after accept.
// cmd_ready_o is high only in IDLE. Command fields are sampled on the accept edge and ignored while busy.
module rf_op_sequencer #(
    parameter  int W  = 16,
    parameter  int R  = 8,
    localparam int AW = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_rd_i,
    input  logic [AW-1:0] cmd_rs0_i,
    input  logic [AW-1:0] cmd_rs1_i,
    input  logic [W-1:0]  cmd_imm_i,
    output logic [W-1:0]  rf_ra0_o,
    output logic [W-1:0]  rf_ra1_o,
    input  logic [W-1:0]  rf_rd0_i,
    input  logic [W-1:0]  rf_rd1_i,
    output logic          rf_wen_o,
    output logic [W-1:0]  rf_wa_o,
    output logic [W-1:0]  rf_wd_o,
    output logic          done_o,
    output logic [W-1:0]  result_o,
    output logic          zero_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MOVI = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs0_q, rs0_d;
    logic [AW-1:0] rs1_q, rs1_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  result_q, result_d;
    logic          accept;

    // Gating with rst_n_i keeps the port closed for the whole reset window.
    assign cmd_ready_o = (state_q == S_IDLE) & rst_n_i;
    assign accept      = cmd_valid_i & cmd_ready_o;

    assign rf_ra0_o = {{(W-AW){1'b0}}, rs0_q};
    assign rf_ra1_o = {{(W-AW){1'b0}}, rs1_q};
    assign rf_wa_o  = {{(W-AW){1'b0}}, rd_q};
    assign rf_wd_o  = res_q;
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs0_q    <= rs0_d;
            rs1_q    <= rs1_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs0_d    = rs0_q;
        rs1_d    = rs1_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        result_d = result_q;
        rf_wen_o = 1'b0;
        done_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = cmd_op_i;
                    rd_d  = cmd_rd_i;
                    rs0_d = cmd_rs0_i;
                    rs1_d = cmd_rs1_i;
                    if (cmd_op_i == OP_MOVI) begin
                        res_d   = cmd_imm_i;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                opa_d   = rf_rd0_i;
                opb_d   = rf_rd1_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  res_d = opa_q + opb_q;
                    OP_SUB:  res_d = opa_q - opb_q;
                    OP_AND:  res_d = opa_q & opb_q;
                    default: res_d = res_q;
                endcase
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rf_wen_o = 1'b1;
                done_o   = 1'b1;
                result_d = res_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
